accelerator_vector_integration_controller: RTL and testbench
============================================================

// Module: accelerator_vector_integration_controller
// PURPOSE
//  Sequencer that streams a SIZE_IN-element float vector through shared scalar float divider/multiplier/adder units to produce its running integral.
//  Step h = LENGTH_IN/PERIOD_IN is computed once per run; then per element acc += h*x[i], emitting acc after each element.
//  Sits between the vector stream interface and the three scalar float units, which are instantiated outside and wired to the *_ADD/*_MUL/*_DIV ports.
// PARAMETERS
//  DATA_SIZE     64  float word width (IEEE-754 binary64 at 64); SIZE_IN is unsigned integer
//  CONTROL_SIZE  64  passed through to sibling units; unused internally
// PORTS
//  CLK              in   1          clock; all logic on rising edge
//  RST              in   1          synchronous, active-high reset
//  START            in   1          1-cycle pulse: latch SIZE_IN/PERIOD_IN/LENGTH_IN, begin run
//  READY            out  1          1-cycle pulse when run completes
//  DATA_IN_ENABLE   in   1          DATA_IN valid (accepted only in S_WAIT_IN)
//  DATA_OUT_ENABLE  out  1          1-cycle pulse: DATA_OUT holds new partial integral
//  SIZE_IN/PERIOD_IN/LENGTH_IN/DATA_IN  in  DATA_SIZE  run config / element x[i]
//  DATA_OUT         out  DATA_SIZE  running integral
//  START_DIV/START_MUL/START_ADD  out 1  1-cycle start pulse to unit
//  READY_DIV/READY_MUL/READY_ADD in  1  unit done pulse; result valid that cycle
//  OPERATION_ADD    out  1          0 = add (always 0 in this block)
//  DATA_A_*/DATA_B_* out DATA_SIZE  operands per unit (*=DIV,MUL,ADD); held stable from START_* until READY_*
//  DATA_OUT_*       in   DATA_SIZE  unit results
// BEHAVIOUR
//  Reset: state S_IDLE; READY, DATA_OUT_ENABLE, START_* , OPERATION_ADD = 0; DATA_OUT, acc, h, count, operands = 0.
//  FSM: S_IDLE -START-> S_DIV (pulse START_DIV, A=LENGTH, B=PERIOD) -READY_DIV-> latch h -> S_WAIT_IN.
//   S_WAIT_IN -DATA_IN_ENABLE-> latch x, pulse START_MUL (A=x, B=h) -> S_MUL -READY_MUL-> pulse START_ADD (A=acc, B=product) -> S_ADD.
//   S_ADD -READY_ADD-> acc=DATA_OUT=sum, DATA_OUT_ENABLE=1 next cycle, count++ -> S_WAIT_IN, or S_DONE if count==SIZE.
//   S_DONE: READY=1 for one cycle -> S_IDLE. acc cleared at START (not at DONE).
//  Latency per element: DATA_IN_ENABLE to DATA_OUT_ENABLE = mul_lat + add_lat + 3 cycles. Unit START pulses the cycle after the triggering event.
//  SIZE_IN==0: no division, no DATA_OUT_ENABLE; READY pulses 2 cycles after START.
//  START while not S_IDLE: ignored. DATA_IN_ENABLE outside S_WAIT_IN: ignored, not buffered (upstream paces on DATA_OUT_ENABLE).
//  READY_* arriving in a state not awaiting it: ignored. count is DATA_SIZE wide, compared against latched SIZE; no wrap within a run.
//  RST mid-run: immediate return to S_IDLE with reset values; in-flight unit results discarded (READY_* ignored in S_IDLE).
//  Simultaneous RST and START: RST wins.
// CONFIGURATION
//  INTEGRATION_TRAPEZOIDAL_EN defined: trapezoidal rule. h replaced by h/2 (extra multiply by FLOAT_HALF after divide);
//   per element: s = x[i]+x[i-1] (adder, x[-1]=0), p = s*(h/2), acc += p; x[i-1] register cleared at START. Adds state S_SUM.
//  Undefined: Euler rule as above (acc += h*x[i]); no S_SUM, no x[i-1] register.
// STRUCTURE
//  Package accelerator_integration_pkg: state enum (S_IDLE,S_DIV,S_HALF,S_WAIT_IN,S_SUM,S_MUL,S_ADD,S_DONE),
//   FLOAT_ZERO, FLOAT_HALF (binary64 0x3FE0000000000000), OP_ADD=0.
//  One sub-module: accelerator_float_op_issue -- issues 1-cycle START, holds operands, flags result on READY;
//   instantiated once per unit (div, mul, add).
// TESTING
//  1 LENGTH=1.0, PERIOD=4.0, SIZE=3, x=[1.0,2.0,3.0] -> h=0.25; DATA_OUT 0.25, 0.75, 1.5; then one READY pulse.
//  2 Same with INTEGRATION_TRAPEZOIDAL_EN -> DATA_OUT 0.125, 0.5, 1.125; READY once.
//  3 SIZE=0, START -> no START_DIV, no DATA_OUT_ENABLE; READY exactly 2 cycles after START.
//  4 Second START and DATA_IN_ENABLE pulses during S_MUL -> ignored; outputs match test 1 exactly; run 2 starts from acc=0.
//  5 RST asserted during S_ADD of element 2 -> next cycle all outputs 0; late READY_ADD ignored; fresh run gives test 1 results.
//  6 Unit models with random 1-20 cycle latency -> operands stable START_*..READY_*; one START_* per op; results unchanged.

Source files
------------

// File: rtl/accelerator_integration_pkg.sv
// accelerator_integration_pkg: sequencer states and binary64 constants shared by the integration controller files.
package accelerator_integration_pkg;
    typedef enum logic [2:0] {S_IDLE, S_DIV, S_HALF, S_WAIT_IN, S_SUM, S_MUL, S_ADD, S_DONE} state_e;
    localparam logic [63:0] FLOAT_ZERO = 64'h0000_0000_0000_0000;
    localparam logic [63:0] FLOAT_HALF = 64'h3FE0_0000_0000_0000;
    localparam logic        OP_ADD     = 1'b0;
endpackage

// File: rtl/accelerator_float_op_issue.sv
// accelerator_float_op_issue: issues a one-cycle START to a scalar float unit, holds its operands
// until the next issue, and flags done only for a READY that answers an outstanding request.
module accelerator_float_op_issue #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ready_i,
    output logic         start_o,
    output logic [W-1:0] data_a_o,
    output logic [W-1:0] data_b_o,
    output logic         done_o
);
    logic         start_q, pending_q;
    logic [W-1:0] a_q, b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q   <= 1'b0;
            pending_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            start_q   <= issue_i;
            pending_q <= issue_i | (pending_q & ~ready_i);
            if (issue_i) begin
                a_q <= a_i;
                b_q <= b_i;
            end
        end
    end

    assign start_o  = start_q;
    assign data_a_o = a_q;
    assign data_b_o = b_q;
    assign done_o   = pending_q & ready_i;
endmodule

// File: rtl/accelerator_vector_integration_controller.sv
// accelerator_vector_integration_controller: streams a float vector through shared div/mul/add units to emit its running integral.
// Define INTEGRATION_TRAPEZOIDAL_EN for the trapezoidal rule; Euler rule otherwise.
module accelerator_vector_integration_controller
    import accelerator_integration_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic                 DATA_IN_ENABLE,
    output logic                 DATA_OUT_ENABLE,
    input  logic [DATA_SIZE-1:0] SIZE_IN,
    input  logic [DATA_SIZE-1:0] PERIOD_IN,
    input  logic [DATA_SIZE-1:0] LENGTH_IN,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic                 START_DIV,
    output logic                 START_MUL,
    output logic                 START_ADD,
    input  logic                 READY_DIV,
    input  logic                 READY_MUL,
    input  logic                 READY_ADD,
    output logic                 OPERATION_ADD,
    output logic [DATA_SIZE-1:0] DATA_A_DIV,
    output logic [DATA_SIZE-1:0] DATA_B_DIV,
    output logic [DATA_SIZE-1:0] DATA_A_MUL,
    output logic [DATA_SIZE-1:0] DATA_B_MUL,
    output logic [DATA_SIZE-1:0] DATA_A_ADD,
    output logic [DATA_SIZE-1:0] DATA_B_ADD,
    input  logic [DATA_SIZE-1:0] DATA_OUT_DIV,
    input  logic [DATA_SIZE-1:0] DATA_OUT_MUL,
    input  logic [DATA_SIZE-1:0] DATA_OUT_ADD
);
    if (CONTROL_SIZE < 1) begin : g_bad_control_size
    end

    state_e               state_q, state_d;
    logic [DATA_SIZE-1:0] size_q, size_d, h_q, h_d, acc_q, acc_d, count_q, count_d, out_q, out_d;
    logic                 doe_q, doe_d, ready_q, ready_d;
    logic                 div_go, mul_go, add_go, div_done, mul_done, add_done;
    logic [DATA_SIZE-1:0] mul_a, mul_b, add_a, add_b;
`ifdef INTEGRATION_TRAPEZOIDAL_EN
    logic [DATA_SIZE-1:0] xp_q, xp_d;
`endif

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        h_d     = h_q;
        acc_d   = acc_q;
        count_d = count_q;
        out_d   = out_q;
        div_go  = 1'b0;
        mul_go  = 1'b0;
        add_go  = 1'b0;
        mul_a   = DATA_IN;
        mul_b   = h_q;
        add_a   = acc_q;
        add_b   = DATA_OUT_MUL;
`ifdef INTEGRATION_TRAPEZOIDAL_EN
        xp_d    = xp_q;
`endif
        case (state_q)
            S_IDLE: if (START) begin
                size_d  = SIZE_IN;
                acc_d   = FLOAT_ZERO[DATA_SIZE-1:0];
                count_d = '0;
`ifdef INTEGRATION_TRAPEZOIDAL_EN
                xp_d    = FLOAT_ZERO[DATA_SIZE-1:0];
`endif
                div_go  = SIZE_IN != '0;
                state_d = div_go ? S_DIV : S_DONE;
            end
            S_DIV: if (div_done) begin
                h_d = DATA_OUT_DIV;
`ifdef INTEGRATION_TRAPEZOIDAL_EN
                mul_go  = 1'b1;
                mul_a   = DATA_OUT_DIV;
                mul_b   = FLOAT_HALF[DATA_SIZE-1:0];
                state_d = S_HALF;
`else
                state_d = S_WAIT_IN;
`endif
            end
`ifdef INTEGRATION_TRAPEZOIDAL_EN
            S_HALF: if (mul_done) begin
                h_d     = DATA_OUT_MUL;
                state_d = S_WAIT_IN;
            end
            S_WAIT_IN: if (DATA_IN_ENABLE) begin
                add_go  = 1'b1;
                add_a   = DATA_IN;
                add_b   = xp_q;
                xp_d    = DATA_IN;
                state_d = S_SUM;
            end
            S_SUM: if (add_done) begin
                mul_go  = 1'b1;
                mul_a   = DATA_OUT_ADD;
                state_d = S_MUL;
            end
`else
            S_WAIT_IN: if (DATA_IN_ENABLE) begin
                mul_go  = 1'b1;
                state_d = S_MUL;
            end
`endif
            S_MUL: if (mul_done) begin
                add_go  = 1'b1;
                state_d = S_ADD;
            end
            S_ADD: if (add_done) begin
                acc_d   = DATA_OUT_ADD;
                out_d   = DATA_OUT_ADD;
                count_d = count_q + 1'b1;
                state_d = count_d == size_q ? S_DONE : S_WAIT_IN;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        doe_d   = state_q == S_ADD && add_done;
        ready_d = state_q == S_DONE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            size_q  <= '0;
            h_q     <= '0;
            acc_q   <= '0;
            count_q <= '0;
            out_q   <= '0;
            doe_q   <= 1'b0;
            ready_q <= 1'b0;
`ifdef INTEGRATION_TRAPEZOIDAL_EN
            xp_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            h_q     <= h_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            out_q   <= out_d;
            doe_q   <= doe_d;
            ready_q <= ready_d;
`ifdef INTEGRATION_TRAPEZOIDAL_EN
            xp_q    <= xp_d;
`endif
        end
    end

    // Each issuer only reports done for a READY answering its own outstanding start.
    accelerator_float_op_issue #(.W(DATA_SIZE)) u_div (
        .clk(CLK), .rst(RST), .issue_i(div_go), .a_i(LENGTH_IN), .b_i(PERIOD_IN), .ready_i(READY_DIV),
        .start_o(START_DIV), .data_a_o(DATA_A_DIV), .data_b_o(DATA_B_DIV), .done_o(div_done)
    );
    accelerator_float_op_issue #(.W(DATA_SIZE)) u_mul (
        .clk(CLK), .rst(RST), .issue_i(mul_go), .a_i(mul_a), .b_i(mul_b), .ready_i(READY_MUL),
        .start_o(START_MUL), .data_a_o(DATA_A_MUL), .data_b_o(DATA_B_MUL), .done_o(mul_done)
    );
    accelerator_float_op_issue #(.W(DATA_SIZE)) u_add (
        .clk(CLK), .rst(RST), .issue_i(add_go), .a_i(add_a), .b_i(add_b), .ready_i(READY_ADD),
        .start_o(START_ADD), .data_a_o(DATA_A_ADD), .data_b_o(DATA_B_ADD), .done_o(add_done)
    );

    assign DATA_OUT        = out_q;
    assign DATA_OUT_ENABLE = doe_q;
    assign READY           = ready_q;
    assign OPERATION_ADD   = OP_ADD;
endmodule

// File: tb/tb_accelerator_vector_integration_controller.sv
// tb_accelerator_vector_integration_controller: scoreboard bench with behavioural div/mul/add unit models.
module tb_accelerator_vector_integration_controller;
    logic        CLK = 1'b0, RST = 1'b1, START = 1'b0, DATA_IN_ENABLE = 1'b0;
    logic [63:0] SIZE_IN = '0, PERIOD_IN = '0, LENGTH_IN = '0, DATA_IN = '0;
    logic        READY, DATA_OUT_ENABLE, START_DIV, START_MUL, START_ADD, OPERATION_ADD;
    logic        READY_DIV, READY_MUL, READY_ADD;
    logic [63:0] DATA_OUT, DATA_A_DIV, DATA_B_DIV, DATA_A_MUL, DATA_B_MUL, DATA_A_ADD, DATA_B_ADD;
    logic [63:0] DATA_OUT_DIV, DATA_OUT_MUL, DATA_OUT_ADD;

    accelerator_vector_integration_controller dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY),
        .DATA_IN_ENABLE(DATA_IN_ENABLE), .DATA_OUT_ENABLE(DATA_OUT_ENABLE),
        .SIZE_IN(SIZE_IN), .PERIOD_IN(PERIOD_IN), .LENGTH_IN(LENGTH_IN), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
        .START_DIV(START_DIV), .START_MUL(START_MUL), .START_ADD(START_ADD),
        .READY_DIV(READY_DIV), .READY_MUL(READY_MUL), .READY_ADD(READY_ADD), .OPERATION_ADD(OPERATION_ADD),
        .DATA_A_DIV(DATA_A_DIV), .DATA_B_DIV(DATA_B_DIV), .DATA_A_MUL(DATA_A_MUL), .DATA_B_MUL(DATA_B_MUL),
        .DATA_A_ADD(DATA_A_ADD), .DATA_B_ADD(DATA_B_ADD),
        .DATA_OUT_DIV(DATA_OUT_DIV), .DATA_OUT_MUL(DATA_OUT_MUL), .DATA_OUT_ADD(DATA_OUT_ADD)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0, n_bad = 0;
    int cyc = 0, ready_cnt = 0, doe_cnt = 0, div_cnt = 0, stab_err = 0, dup_err = 0;
    bit rand_lat = 1'b0;
    int fix_lat[3] = '{4, 2, 3};
    logic [63:0] exp_q[$];
    real xv[5];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Unit models: index 0 = div, 1 = mul, 2 = add.
    logic        st[3], rd[3] = '{1'b0, 1'b0, 1'b0}, busy[3] = '{1'b0, 1'b0, 1'b0};
    logic [63:0] oa[3], ob[3], cap_a[3], cap_b[3], res[3] = '{64'h0, 64'h0, 64'h0}, pend[3];
    int          cnt[3] = '{0, 0, 0};
    assign st[0] = START_DIV;
    assign st[1] = START_MUL;
    assign st[2] = START_ADD;
    assign oa[0] = DATA_A_DIV;
    assign oa[1] = DATA_A_MUL;
    assign oa[2] = DATA_A_ADD;
    assign ob[0] = DATA_B_DIV;
    assign ob[1] = DATA_B_MUL;
    assign ob[2] = DATA_B_ADD;
    assign READY_DIV    = rd[0];
    assign READY_MUL    = rd[1];
    assign READY_ADD    = rd[2];
    assign DATA_OUT_DIV = res[0];
    assign DATA_OUT_MUL = res[1];
    assign DATA_OUT_ADD = res[2];

    always @(posedge CLK) cyc++;

    always @(posedge CLK) begin
        for (int u = 0; u < 3; u++) begin : unit
            int  lat;
            real a, b, r;
            rd[u] <= 1'b0;
            if (RST) begin
                cap_a[u] <= '0;
                cap_b[u] <= '0;
            end else if (busy[u] && (oa[u] !== cap_a[u] || ob[u] !== cap_b[u])) stab_err++;
            if (st[u] === 1'b1) begin
                if (busy[u]) dup_err++;
                a = $bitstoreal(oa[u]);
                b = $bitstoreal(ob[u]);
                r = (u == 0) ? a / b : (u == 1) ? a * b : a + b;
                lat = rand_lat ? int'($urandom_range(20, 1)) : fix_lat[u];
                cap_a[u] <= oa[u];
                cap_b[u] <= ob[u];
                if (lat == 1) begin
                    rd[u]   <= 1'b1;
                    res[u]  <= $realtobits(r);
                    busy[u] <= 1'b0;
                end else begin
                    busy[u] <= 1'b1;
                    cnt[u]  <= lat - 1;
                    pend[u] <= $realtobits(r);
                end
            end else if (busy[u]) begin
                if (cnt[u] == 1) begin
                    rd[u]   <= 1'b1;
                    res[u]  <= pend[u];
                    busy[u] <= 1'b0;
                end else cnt[u] <= cnt[u] - 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (DATA_OUT_ENABLE === 1'b1) begin
            doe_cnt++;
            if (exp_q.size() == 0) chk("extra_doe", 64'd1, 64'd0);
            else chk("data_out", DATA_OUT, exp_q.pop_front());
        end
        if (READY === 1'b1) ready_cnt++;
        if (START_DIV === 1'b1) div_cnt++;
    end

    function automatic logic sig(input int s);
        case (s)
            0: return READY_DIV;
            1: return READY_MUL;
            2: return DATA_OUT_ENABLE;
            3: return START_MUL;
            4: return START_ADD;
            5: return READY;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int s);
        int k = 0;
        while (sig(s) !== 1'b1 && k < 400) begin
            @(negedge CLK);
            k++;
        end
        chk(tag, 64'(sig(s)), 64'd1);
    endtask

    // mode 0: plain run; 1: stray START/DATA_IN_ENABLE during S_MUL; 2: reset during element 2.
    task automatic do_run(input real len, input real per, input int n, input int mode);
        real hm, acc, xp;
        int  r0, d0, t_in;
        r0 = ready_cnt;
        d0 = div_cnt;
        hm = len / per;
`ifdef INTEGRATION_TRAPEZOIDAL_EN
        hm = hm * 0.5;
`endif
        acc = 0.0;
        xp = 0.0;
        t_in = 0;
        START = 1'b1;
        SIZE_IN = 64'(n);
        LENGTH_IN = $realtobits(len);
        PERIOD_IN = $realtobits(per);
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                wait_sig("div_ready", 0);
                @(negedge CLK);
`ifdef INTEGRATION_TRAPEZOIDAL_EN
                wait_sig("half_ready", 1);
                @(negedge CLK);
`endif
            end else begin
                wait_sig("doe_wait", 2);
`ifndef INTEGRATION_TRAPEZOIDAL_EN
                if (i == 1 && !rand_lat) chk("latency", 64'(cyc - t_in), 64'(fix_lat[1] + fix_lat[2] + 3));
`endif
            end
            DATA_IN = $realtobits(xv[i]);
            DATA_IN_ENABLE = 1'b1;
            t_in = cyc;
`ifdef INTEGRATION_TRAPEZOIDAL_EN
            acc = acc + (xv[i] + xp) * hm;
            xp = xv[i];
`else
            acc = acc + xv[i] * hm;
`endif
            exp_q.push_back($realtobits(acc));
            @(negedge CLK);
            DATA_IN_ENABLE = 1'b0;
            if (mode == 1 && i == 0) begin
                wait_sig("mul_start", 3);
                START = 1'b1;
                SIZE_IN = 64'd7;
                DATA_IN = $realtobits(99.0);
                DATA_IN_ENABLE = 1'b1;
                @(negedge CLK);
                START = 1'b0;
                DATA_IN_ENABLE = 1'b0;
            end
            if (mode == 2 && i == 1) begin
                wait_sig("add_start", 4);
                @(negedge CLK);
                RST = 1'b1;
                exp_q.delete();
                @(negedge CLK);
                RST = 1'b0;
                chk("rst_mid_ctl", 64'({READY, DATA_OUT_ENABLE, START_DIV, START_MUL, START_ADD, OPERATION_ADD}), 64'd0);
                chk("rst_mid_data", DATA_OUT | DATA_A_ADD | DATA_B_ADD | DATA_A_MUL | DATA_B_MUL | DATA_A_DIV | DATA_B_DIV, 64'd0);
                repeat (40) @(negedge CLK);
                chk("rst_no_ready", 64'(ready_cnt - r0), 64'd0);
                return;
            end
        end
        wait_sig("ready_wait", 5);
        chk("final", DATA_OUT, $realtobits(acc));
        repeat (3) @(negedge CLK);
        chk("ready_once", 64'(ready_cnt - r0), 64'd1);
        chk("div_once", 64'(div_cnt - d0), 64'd1);
        chk("drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int t, d0, o0;
        real lit;
`ifdef INTEGRATION_TRAPEZOIDAL_EN
        lit = 1.125;
`else
        lit = 1.5;
`endif
        repeat (3) @(negedge CLK);
        chk("rst_ctl", 64'({READY, DATA_OUT_ENABLE, START_DIV, START_MUL, START_ADD}), 64'd0);
        chk("rst_op_add", 64'(OPERATION_ADD), 64'd0);
        chk("rst_data", DATA_OUT | DATA_A_ADD | DATA_B_ADD | DATA_A_MUL | DATA_B_MUL | DATA_A_DIV | DATA_B_DIV, 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        xv = '{1.0, 2.0, 3.0, 0.0, 0.0};
        do_run(1.0, 4.0, 3, 0);
        chk("t1_literal", DATA_OUT, $realtobits(lit));
        d0 = div_cnt;
        o0 = doe_cnt;
        START = 1'b1;
        SIZE_IN = 64'd0;
        t = cyc;
        @(negedge CLK);
        START = 1'b0;
        wait_sig("sz0_ready", 5);
        chk("sz0_latency", 64'(cyc - t), 64'd2);
        repeat (4) @(negedge CLK);
        chk("sz0_no_div", 64'(div_cnt - d0), 64'd0);
        chk("sz0_no_doe", 64'(doe_cnt - o0), 64'd0);
        do_run(1.0, 4.0, 3, 1);
        chk("t4_literal", DATA_OUT, $realtobits(lit));
        do_run(1.0, 4.0, 3, 0);
        do_run(1.0, 4.0, 3, 2);
        do_run(1.0, 4.0, 3, 0);
        chk("t5_literal", DATA_OUT, $realtobits(lit));
        rand_lat = 1'b1;
        xv = '{0.5, -1.25, 3.0, 2.5, 7.75};
        do_run(3.0, 8.0, 5, 0);
        do_run(1.0, 4.0, 4, 0);
        repeat (30) @(negedge CLK);
        chk("operand_stable", 64'(stab_err), 64'd0);
        chk("single_start", 64'(dup_err), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
